unidade_controle_jogo: RTL and testbench

//   Moore FSM that sequences the memory-game datapath (address counter E, sequence-limit counter S, play register R, comparators).

---
 rtl/unidade_controle_jogo_pkg.sv | 18 +
 rtl/unidade_controle_jogo_detector_borda.sv | 17 +
 rtl/unidade_controle_jogo.sv | 82 ++++++++
 tb/tb_unidade_controle_jogo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_jogo_pkg.sv
// unidade_controle_jogo_pkg: state codes of the memory-game controller, shared with the datapath display decode and benches.
package unidade_controle_jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        NOVA_SEQ    = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROX_JOGADA = 4'h6,
        PROX_SEQ    = 4'h7,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_jogo_detector_borda.sv
// detector_borda: one-cycle pulse on each rising edge of sinal.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;

    always_ff @(posedge clock or negedge reset)
        if (!reset) sinal_q <= 1'b0;
        else        sinal_q <= sinal;

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing the memory-game datapath through rounds of growing length.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int CNT_W          = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       tem_jogada,
    input  logic       jogada_igual_memoria,
    input  logic       endereco_igual_sequencia,
    input  logic       fim_s,
    output logic       zera_e,
    output logic       conta_e,
    output logic       zera_s,
    output logic       conta_s,
    output logic       zera_r,
    output logic       registra_r,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    estado_t          estado, proximo;
    logic [CNT_W-1:0] cnt;
    logic             evt, timeout;

    detector_borda u_borda (
        .clock (clock),
        .reset (reset),
        .sinal (tem_jogada),
        .pulso (evt)
    );

    assign timeout = (TIMEOUT_CICLOS != 0) && (cnt == CNT_W'(TIMEOUT_CICLOS - 1));

    // Counter only runs in ESPERA, so every entry there starts from zero.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            estado <= INICIAL;
            cnt    <= '0;
        end else begin
            estado <= proximo;
            cnt    <= (estado == ESPERA) ? cnt + CNT_W'(1) : '0;
        end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:     proximo = jogar ? PREPARA : INICIAL;
            PREPARA:     proximo = NOVA_SEQ;
            NOVA_SEQ:    proximo = ESPERA;
            ESPERA:      proximo = evt ? REGISTRA : timeout ? FIM_TIMEOUT : ESPERA;
            REGISTRA:    proximo = COMPARA;
            COMPARA:     proximo = !jogada_igual_memoria ? FIM_ERRO :
                                   !endereco_igual_sequencia ? PROX_JOGADA :
                                   fim_s ? FIM_ACERTO : PROX_SEQ;
            PROX_JOGADA: proximo = ESPERA;
            PROX_SEQ:    proximo = NOVA_SEQ;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
                         proximo = jogar ? PREPARA : estado;
            default:     proximo = INICIAL;
        endcase
    end

    assign zera_e     = (estado == PREPARA) || (estado == NOVA_SEQ);
    assign conta_e    = (estado == PROX_JOGADA);
    assign zera_s     = (estado == PREPARA);
    assign conta_s    = (estado == PROX_SEQ);
    assign zera_r     = (estado == PREPARA);
    assign registra_r = (estado == REGISTRA);
    assign pronto     = (estado == FIM_ACERTO) || (estado == FIM_TIMEOUT) || (estado == FIM_ERRO);
    assign ganhou     = (estado == FIM_ACERTO);
    assign perdeu     = (estado == FIM_TIMEOUT) || (estado == FIM_ERRO);
    assign db_timeout = (estado == FIM_TIMEOUT);
    assign db_estado  = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: directed game scenarios with a behavioural game model checked every cycle.
module tb_unidade_controle_jogo;

    localparam int T = 40;

    logic       clock = 1'b0, reset = 1'b0, jogar = 1'b0;
    logic [3:0] botoes = 4'b0;
    logic       tem_jogada, jogada_igual_memoria, endereco_igual_sequencia, fim_s;
    logic       zera_e, conta_e, zera_s, conta_s, zera_r, registra_r;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    int checks = 0, failures = 0;
    int n_e = 0, n_s = 0, n_r = 0;

    always #5 clock = ~clock;

    unidade_controle_jogo #(.TIMEOUT_CICLOS(T), .CNT_W(12)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .jogar                    (jogar),
        .tem_jogada               (tem_jogada),
        .jogada_igual_memoria     (jogada_igual_memoria),
        .endereco_igual_sequencia (endereco_igual_sequencia),
        .fim_s                    (fim_s),
        .zera_e                   (zera_e),
        .conta_e                  (conta_e),
        .zera_s                   (zera_s),
        .conta_s                  (conta_s),
        .zera_r                   (zera_r),
        .registra_r               (registra_r),
        .pronto                   (pronto),
        .ganhou                   (ganhou),
        .perdeu                   (perdeu),
        .db_timeout               (db_timeout),
        .db_estado                (db_estado)
    );

    // Datapath environment: 4-entry sequence memory, counters E/S and play register R.
    logic [3:0] mem [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] e_reg, s_reg;
    logic [3:0] r_reg;

    always @(posedge clock or negedge reset)
        if (!reset) begin
            e_reg <= 2'd0;
            s_reg <= 2'd0;
            r_reg <= 4'd0;
        end else begin
            if (zera_e) e_reg <= 2'd0; else if (conta_e) e_reg <= e_reg + 2'd1;
            if (zera_s) s_reg <= 2'd0; else if (conta_s) s_reg <= s_reg + 2'd1;
            if (zera_r) r_reg <= 4'd0; else if (registra_r) r_reg <= botoes;
        end

    assign tem_jogada               = |botoes;
    assign jogada_igual_memoria     = (r_reg == mem[e_reg]);
    assign endereco_igual_sequencia = (e_reg == s_reg);
    assign fim_s                    = (s_reg == 2'd3);

    // Game model: phase code, cycles already waited for the current play, last button level.
    int   m_code, m_wait;
    logic m_q;

    function automatic int prox(int c, int waited, logic ev, logic j, logic ig, logic ult, logic fs);
        if (c == 0) return j ? 1 : 0;
        if (c == 1 || c == 7) return 2;
        if (c == 2 || c == 6) return 3;
        if (c == 3) return ev ? 4 : (T != 0 && waited + 1 == T) ? 13 : 3;
        if (c == 4) return 5;
        if (c == 5) return !ig ? 14 : !ult ? 6 : fs ? 10 : 7;
        if (c == 10 || c == 13 || c == 14) return j ? 1 : c;
        return 0;
    endfunction

    function automatic logic [9:0] saidas(int c);
        return {c == 1 || c == 2, c == 6, c == 1, c == 7, c == 1, c == 4,
                c == 10 || c == 13 || c == 14, c == 10, c == 13 || c == 14, c == 13};
    endfunction

    always @(posedge clock or negedge reset)
        if (!reset) begin
            m_code <= 0;
            m_wait <= 0;
            m_q    <= 1'b0;
        end else begin
            m_code <= prox(m_code, m_wait, tem_jogada & ~m_q, jogar,
                           jogada_igual_memoria, endereco_igual_sequencia, fim_s);
            m_wait <= (m_code == 3) ? m_wait + 1 : 0;
            m_q    <= tem_jogada;
        end

    logic [9:0] outs;
    assign outs = {zera_e, conta_e, zera_s, conta_s, zera_r, registra_r, pronto, ganhou, perdeu, db_timeout};

    always @(negedge clock) begin
        checks++;
        if (db_estado !== 4'(m_code) || outs !== saidas(m_code)) begin
            failures++;
            $display("FAIL model t=%0t estado=%h exp=%h outs=%b exp=%b", $time, db_estado, 4'(m_code), outs, saidas(m_code));
        end
        n_e += int'(conta_e);
        n_s += int'(conta_s);
        n_r += int'(registra_r);
    end

    task automatic chk(string nome, logic [31:0] atual, logic [31:0] exp_v);
        checks++;
        if (atual !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nome, atual, exp_v);
        end
    endtask

    task automatic esperar(logic [3:0] cod, int lim);
        int k = 0;
        while (db_estado !== cod && k < lim) begin
            @(negedge clock);
            k++;
        end
        chk("espera_estado", 32'(db_estado), 32'(cod));
    endtask

    task automatic jogada(logic [3:0] v);
        esperar(4'h3, 50);
        botoes = v;
        repeat (10) @(negedge clock);
        botoes = 4'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic iniciar();
        @(negedge clock);
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    int b_e, b_s, b_r, n;
    int seq_esp [5] = '{1, 2, 3, 3, 3};

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_estado", 32'(db_estado), 0);
        chk("reset_saidas", 32'(outs), 0);
        #2 reset = 1'b1;
        // Test 2: jogar held 5 cycles
        @(negedge clock);
        jogar = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("jogar_seq", 32'(db_estado), 32'(seq_esp[i]));
            if (i == 0) chk("prepara_zeras", 32'({zera_e, zera_s, zera_r}), 32'h7);
        end
        jogar = 1'b0;
        // Test 1: reset mid-ESPERA
        #2 reset = 1'b0;
        #1 chk("reset_meio_estado", 32'(db_estado), 0);
        chk("reset_meio_saidas", 32'(outs), 0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        chk("pos_reset_estado", 32'(db_estado), 0);
        // Test 3/4: rounds S=0..2 correct, loss in round 4
        b_e = n_e; b_s = n_s;
        iniciar();
        jogada(4'b0001);
        jogada(4'b0001); jogada(4'b0010);
        jogada(4'b0001); jogada(4'b0010); jogada(4'b0100);
        chk("conta_e_rodadas", 32'(n_e - b_e), 3);
        chk("conta_s_rodadas", 32'(n_s - b_s), 3);
        jogada(4'b0001);
        jogada(4'b1010);
        chk("erro_estado", 32'(db_estado), 32'hE);
        chk("erro_flags", 32'({pronto, perdeu, ganhou}), 32'b110);
        iniciar();
        chk("reinicio", 32'(db_estado), 1);
        // Test 5: timeout, then play in the last allowed cycle
        esperar(4'h3, 10);
        n = 0;
        while (db_estado == 4'h3 && n < T + 5) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_ciclos", 32'(n), 32'(T));
        chk("timeout_estado", 32'(db_estado), 32'hD);
        chk("timeout_flags", 32'({pronto, perdeu, db_timeout, ganhou}), 32'b1110);
        iniciar();
        esperar(4'h3, 10);
        repeat (T - 1) @(negedge clock);
        botoes = 4'b0001;
        @(negedge clock);
        chk("evt_vence_timeout", 32'(db_estado), 4);
        repeat (8) @(negedge clock);
        botoes = 4'b0;
        // Test 6: full win
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        b_e = n_e; b_s = n_s; b_r = n_r;
        iniciar();
        for (int r = 0; r < 4; r++)
            for (int p = 0; p <= r; p++) jogada(mem[p]);
        esperar(4'hA, 20);
        chk("vitoria_flags", 32'({pronto, ganhou, perdeu}), 32'b110);
        chk("registra_por_jogada", 32'(n_r - b_r), 10);
        chk("conta_e_vitoria", 32'(n_e - b_e), 6);
        chk("conta_s_vitoria", 32'(n_s - b_s), 3);
        repeat (3) @(negedge clock);
        chk("vitoria_mantida", 32'(db_estado), 32'hA);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
